tile_scheduler: RTL and testbench

TILE_SCHEDULER -- requirements
Module: tile_scheduler

---
 rtl/tile_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_tile_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks the screen tile by tile, handing each tile to a raster
// engine and then to a stream engine through a small pool of tile buffers,
// and flips the displayed page once every tile of the frame has been streamed.
module tile_scheduler #(
  parameter int TILE_DIM = 8,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int NUM_BUFS = 2,
  parameter int COORD_W  = 10,
  localparam int ID_W    = $clog2(NUM_BUFS)
) (
  input  logic               BOARD_CLK,
  input  logic               RESET_N,
  input  logic               frame_enable,
  output logic               raster_start,
  output logic [ID_W-1:0]    raster_tile_id,
  output logic [COORD_W-1:0] raster_x,
  output logic [COORD_W-1:0] raster_y,
  input  logic               raster_done,
  output logic               stream_start,
  output logic [ID_W-1:0]    stream_tile_id,
  output logic [COORD_W-1:0] stream_x,
  output logic [COORD_W-1:0] stream_y,
  input  logic               stream_done,
  output logic               front_buffer,
  output logic               frame_done,
  output logic               busy
);

  localparam int TILES_X = SCREEN_W / TILE_DIM;
  localparam int TOTAL   = TILES_X * (SCREEN_H / TILE_DIM);
  localparam int CNT_W   = $clog2(TOTAL + 1);
  localparam int OCC_W   = $clog2(NUM_BUFS + 1);

  localparam logic [CNT_W-1:0]   CNT_TOTAL = CNT_W'(TOTAL);
  localparam logic [OCC_W-1:0]   OCC_FULL  = OCC_W'(NUM_BUFS);
  localparam logic [COORD_W-1:0] STEP      = COORD_W'(TILE_DIM);
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(SCREEN_W - TILE_DIM);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(SCREEN_H - TILE_DIM);

  typedef enum logic [1:0] {IDLE, RUN, SWAP} state_t;

  state_t state, state_nxt;

  logic               raster_busy, stream_busy;
  logic [CNT_W-1:0]   issued, streamed, streamed_nxt;
  logic [OCC_W-1:0]   occ, occ_after;
  logic [COORD_W-1:0] cur_x, cur_y;

  logic [ID_W-1:0]    fifo_id [NUM_BUFS];
  logic [COORD_W-1:0] fifo_x  [NUM_BUFS];
  logic [COORD_W-1:0] fifo_y  [NUM_BUFS];
  logic [ID_W-1:0]    wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   fifo_count;

  logic               raster_fin, stream_fin, frame_go;
  logic               raster_go, stream_go, fifo_push, fifo_pop;
  logic [ID_W-1:0]    head_id;
  logic [COORD_W-1:0] head_x, head_y;

  // Done pulses only count while the matching engine holds a job.
  assign raster_fin   = raster_done & raster_busy;
  assign stream_fin   = stream_done & stream_busy;
  assign frame_go     = (state == IDLE) && frame_enable;
  assign occ_after    = occ - OCC_W'(stream_fin);
  assign streamed_nxt = streamed + CNT_W'(stream_fin);
  assign fifo_push    = raster_fin;
  assign fifo_pop     = stream_go;

  // Start decisions look at this cycle's done pulses so a start can be
  // registered on the very edge that retires the previous job.
  assign raster_go = (state == RUN) && (!raster_busy || raster_fin) &&
                     (occ_after < OCC_FULL) && (issued < CNT_TOTAL);
  assign stream_go = (state == RUN) && (!stream_busy || stream_fin) &&
                     ((fifo_count != '0) || fifo_push);

  // Ready FIFO head; an empty FIFO forwards the entry being pushed this cycle.
  always_comb begin
    head_id = fifo_id[rd_ptr];
    head_x  = fifo_x[rd_ptr];
    head_y  = fifo_y[rd_ptr];
    if (fifo_count == '0) begin
      head_id = raster_tile_id;
      head_x  = raster_x;
      head_y  = raster_y;
    end
  end

  // State register.
  always_ff @(posedge BOARD_CLK) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: leave RUN as soon as the final stream_done is seen.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_enable) state_nxt = RUN;
      RUN:     if (streamed_nxt == CNT_TOTAL) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy       = (state != IDLE);
    frame_done = (state == SWAP);
  end

  // Raster channel: issue tiles in raster order and walk the cursor.
  always_ff @(posedge BOARD_CLK) begin
    if (!RESET_N) begin
      raster_start   <= 1'b0;
      raster_tile_id <= '0;
      raster_x       <= '0;
      raster_y       <= '0;
      raster_busy    <= 1'b0;
      issued         <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
    end else if (frame_go) begin
      raster_start <= 1'b0;
      raster_busy  <= 1'b0;
      issued       <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
    end else begin
      raster_start <= raster_go;
      if (raster_go) begin
        raster_busy    <= 1'b1;
        raster_tile_id <= issued[ID_W-1:0];
        raster_x       <= cur_x;
        raster_y       <= cur_y;
        issued         <= issued + CNT_W'(1);
        if (cur_x == X_LAST) begin
          cur_x <= '0;
          if (cur_y != Y_LAST) cur_y <= cur_y + STEP;
        end else begin
          cur_x <= cur_x + STEP;
        end
      end else if (raster_fin) begin
        raster_busy <= 1'b0;
      end
    end
  end

  // Stream channel plus buffer occupancy and streamed-tile count.
  always_ff @(posedge BOARD_CLK) begin
    if (!RESET_N) begin
      stream_start   <= 1'b0;
      stream_tile_id <= '0;
      stream_x       <= '0;
      stream_y       <= '0;
      stream_busy    <= 1'b0;
      streamed       <= '0;
      occ            <= '0;
    end else if (frame_go) begin
      stream_start <= 1'b0;
      stream_busy  <= 1'b0;
      streamed     <= '0;
      occ          <= '0;
    end else begin
      stream_start <= stream_go;
      if (stream_go) begin
        stream_busy    <= 1'b1;
        stream_tile_id <= head_id;
        stream_x       <= head_x;
        stream_y       <= head_y;
      end else if (stream_fin) begin
        stream_busy <= 1'b0;
      end
      streamed <= streamed_nxt;
      occ      <= occ_after + OCC_W'(raster_go);
    end
  end

  // Ready FIFO of rastered tiles awaiting a stream slot.
  always_ff @(posedge BOARD_CLK) begin
    if (!RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < NUM_BUFS; i++) begin
        fifo_id[i] <= '0;
        fifo_x[i]  <= '0;
        fifo_y[i]  <= '0;
      end
    end else if (frame_go) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        fifo_id[wr_ptr] <= raster_tile_id;
        fifo_x[wr_ptr]  <= raster_x;
        fifo_y[wr_ptr]  <= raster_y;
        wr_ptr          <= wr_ptr + ID_W'(1);
      end
      if (fifo_pop) rd_ptr <= rd_ptr + ID_W'(1);
      fifo_count <= fifo_count + OCC_W'(fifo_push) - OCC_W'(fifo_pop);
    end
  end

  // Displayed page flips once per completed frame.
  always_ff @(posedge BOARD_CLK) begin
    if (!RESET_N)            front_buffer <= 1'b0;
    else if (state == SWAP)  front_buffer <= ~front_buffer;
  end

  // Occupancy gating must keep the ready FIFO from ever overflowing.
  fifo_no_overflow: assert property (@(posedge BOARD_CLK) disable iff (!RESET_N)
    !(fifo_push && !fifo_pop && (fifo_count == OCC_FULL)));

endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: random-latency engine responders, a frame-level tile
// model feeding expected raster/stream queues, and a monitor that scores
// every start pulse and frame completion.
module tb_tile_scheduler;

  localparam int TD = 8;
  localparam int SW = 32;
  localparam int SH = 16;
  localparam int NB = 2;
  localparam int CW = 10;
  localparam int IW = $clog2(NB);
  localparam int TILES_X = SW / TD;
  localparam int NTILES  = TILES_X * (SH / TD);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, frame_enable;
  logic          rsp_rdone, spur_rdone, rsp_sdone, spur_sdone;
  logic          raster_done, stream_done;
  logic          raster_start, stream_start, front_buffer, frame_done, busy;
  logic [IW-1:0] raster_tile_id, stream_tile_id;
  logic [CW-1:0] raster_x, raster_y, stream_x, stream_y;

  assign raster_done = rsp_rdone | spur_rdone;
  assign stream_done = rsp_sdone | spur_sdone;

  tile_scheduler #(
    .TILE_DIM(TD), .SCREEN_W(SW), .SCREEN_H(SH), .NUM_BUFS(NB), .COORD_W(CW)
  ) dut (
    .BOARD_CLK(clk), .RESET_N(rst_n), .frame_enable(frame_enable),
    .raster_start(raster_start), .raster_tile_id(raster_tile_id),
    .raster_x(raster_x), .raster_y(raster_y), .raster_done(raster_done),
    .stream_start(stream_start), .stream_tile_id(stream_tile_id),
    .stream_x(stream_x), .stream_y(stream_y), .stream_done(stream_done),
    .front_buffer(front_buffer), .frame_done(frame_done), .busy(busy)
  );

  typedef struct {int id; int x; int y;} tile_t;
  tile_t r_q[$];
  tile_t s_q[$];
  tile_t mt;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus controls
  bit mon_en = 0;
  bit s_hold = 0;
  int r_lat_lo = 3, r_lat_hi = 3, s_lat_lo = 3, s_lat_hi = 3;

  // Monitor-side model of the scheduler's bookkeeping
  int m_occ, m_ready, r_frame_cnt, s_frame_cnt, r_total;
  bit m_rbusy, m_sbusy, fb_exp, fb_pending;
  int frames_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected tiles of one frame, straight from the screen geometry.
  task automatic push_frame();
    tile_t t;
    for (int n = 0; n < NTILES; n++) begin
      t.id = n % NB;
      t.x  = (n % TILES_X) * TD;
      t.y  = (n / TILES_X) * TD;
      r_q.push_back(t);
      s_q.push_back(t);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_raster_start"}, raster_start, 0);
    chk({tag, "_stream_start"}, stream_start, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_front_buffer"}, front_buffer, 0);
    chk({tag, "_raster_id"}, raster_tile_id, 0);
    chk({tag, "_raster_xy"}, raster_x + raster_y, 0);
    chk({tag, "_stream_id"}, stream_tile_id, 0);
    chk({tag, "_stream_xy"}, stream_x + stream_y, 0);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (frames_seen < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("frame_count_reached", frames_seen, target);
  endtask

  // Monitor: scores starts against the queues and gating rules.
  always @(negedge clk) begin
    if (!mon_en) begin
      m_occ = 0; m_ready = 0; m_rbusy = 0; m_sbusy = 0;
      r_frame_cnt = 0; s_frame_cnt = 0; fb_exp = 0; fb_pending = 0;
      r_q.delete(); s_q.delete();
    end else begin
      if (fb_pending) begin
        chk("front_buffer_toggle", front_buffer, fb_exp);
        fb_pending = 0;
      end
      if (raster_start) begin
        chk("raster_gate_occupancy", m_occ < NB, 1);
        chk("raster_gate_engine_idle", m_rbusy, 0);
        if (r_q.size() == 0) chk("raster_start_unexpected", raster_start, 0);
        else begin
          mt = r_q.pop_front();
          chk("raster_tile_id", raster_tile_id, mt.id);
          chk("raster_x", raster_x, mt.x);
          chk("raster_y", raster_y, mt.y);
        end
        m_rbusy = 1; m_occ++; r_frame_cnt++; r_total++;
      end
      if (stream_start) begin
        chk("stream_gate_ready", m_ready > 0, 1);
        chk("stream_gate_engine_idle", m_sbusy, 0);
        if (s_q.size() == 0) chk("stream_start_unexpected", stream_start, 0);
        else begin
          mt = s_q.pop_front();
          chk("stream_tile_id", stream_tile_id, mt.id);
          chk("stream_x", stream_x, mt.x);
          chk("stream_y", stream_y, mt.y);
        end
        m_sbusy = 1; m_ready--;
      end
      if (raster_done && m_rbusy) begin m_rbusy = 0; m_ready++; end
      if (stream_done && m_sbusy) begin m_sbusy = 0; m_occ--; s_frame_cnt++; end
      if (frame_done) begin
        frames_seen++;
        chk("tiles_per_frame", s_frame_cnt, NTILES);
        chk("busy_in_swap", busy, 1);
        s_frame_cnt = 0; r_frame_cnt = 0;
        fb_exp = ~fb_exp; fb_pending = 1;
      end
    end
  end

  // Raster engine responder.
  initial begin
    int n;
    bit ab;
    rsp_rdone = 0;
    forever begin
      @(negedge clk);
      if (raster_start && rst_n) begin
        n = $urandom_range(r_lat_hi, r_lat_lo);
        ab = 0;
        for (int i = 0; i < n; i++) begin
          @(posedge clk);
          if (!rst_n) ab = 1;
        end
        #1;
        if (!ab && rst_n) begin
          rsp_rdone = 1;
          @(posedge clk);
          #1 rsp_rdone = 0;
        end
      end
    end
  end

  // Stream engine responder, can be held off to create back-pressure.
  initial begin
    int n;
    bit ab;
    rsp_sdone = 0;
    forever begin
      @(negedge clk);
      if (stream_start && rst_n) begin
        n = $urandom_range(s_lat_hi, s_lat_lo);
        ab = 0;
        for (int i = 0; i < n; i++) begin
          @(posedge clk);
          if (!rst_n) ab = 1;
        end
        while (s_hold && !ab) begin
          @(posedge clk);
          if (!rst_n) ab = 1;
        end
        #1;
        if (!ab && rst_n) begin
          rsp_sdone = 1;
          @(posedge clk);
          #1 rsp_sdone = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    rst_n = 0; frame_enable = 0; spur_rdone = 0; spur_sdone = 0;
    r_total = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1; mon_en = 1;

    // Spurious done pulses while idle
    repeat (2) @(posedge clk);
    #1 spur_rdone = 1; spur_sdone = 1;
    @(posedge clk); #1 spur_rdone = 0; spur_sdone = 0;
    repeat (4) @(negedge clk);
    chk("spurious_busy", busy, 0);
    chk("spurious_no_start", r_total, 0);

    // Frame A: fixed 3-cycle latencies, enable dropped mid-frame
    push_frame();
    @(posedge clk); #1 frame_enable = 1;
    @(posedge clk); #1 frame_enable = 0;
    wait_frames(1, 400);
    repeat (3) @(negedge clk);
    chk("frame_a_front_buffer", front_buffer, 1);
    chk("frame_a_idle", busy, 0);

    // Frame B: stream back-pressure stalls raster at full occupancy
    s_hold = 1; r_lat_lo = 2; r_lat_hi = 2; s_lat_lo = 1; s_lat_hi = 1;
    push_frame();
    @(posedge clk); #1 frame_enable = 1;
    @(posedge clk); #1 frame_enable = 0;
    for (int k = 0; k < 100 && r_frame_cnt < 2; k++) @(posedge clk);
    repeat (12) @(negedge clk);
    chk("stall_raster_count", r_frame_cnt, 2);
    @(posedge clk); #1 s_hold = 0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (stream_done) break;
    end
    for (int k = 0; k < 2 && got == 0; k++) begin
      @(negedge clk);
      if (raster_start) got = 1;
    end
    chk("resume_within_2", got, 1);
    wait_frames(2, 600);
    repeat (3) @(negedge clk);
    chk("frame_b_front_buffer", front_buffer, 0);

    // Frames C and D: random latencies, enable held across both frames
    r_lat_lo = 1; r_lat_hi = 4; s_lat_lo = 1; s_lat_hi = 4;
    push_frame();
    push_frame();
    @(posedge clk); #1 frame_enable = 1;
    wait_frames(3, 600);
    wait_frames(4, 600);
    #1 frame_enable = 0;
    repeat (6) @(negedge clk);
    chk("pair_front_buffer", front_buffer, 0);
    chk("pair_frames_done", frames_seen, 4);
    chk("pair_idle", busy, 0);

    // Frame E: reset after the 5th raster start, then restart with enable high
    r_lat_lo = 3; r_lat_hi = 3; s_lat_lo = 3; s_lat_hi = 3;
    push_frame();
    @(posedge clk); #1 frame_enable = 1;
    @(posedge clk); #1 frame_enable = 0;
    for (int k = 0; k < 200 && r_frame_cnt < 5; k++) @(posedge clk);
    chk("pre_reset_starts", r_frame_cnt, 5);
    #1 rst_n = 0; mon_en = 0; frame_enable = 1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midframe_reset");
    @(posedge clk); #1 rst_n = 1; mon_en = 1;
    push_frame();
    @(posedge clk); #1 frame_enable = 0;
    wait_frames(5, 600);
    repeat (3) @(negedge clk);
    chk("restart_front_buffer", front_buffer, 1);

    chk("raster_queue_drained", r_q.size(), 0);
    chk("stream_queue_drained", s_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
